// File: rtl/sha1_pkg.sv
// Shared constants for the sha1 core and its message padder: block geometry,
// padder FSM state codes and the FIPS 180-4 initial hash values.
package sha1_pkg;

  localparam int BLOCK_BITS  = 512;
  localparam int BLOCK_BYTES = 64;
  localparam logic [7:0] PAD_BYTE = 8'h80;
  localparam int LEN_POS = 56;

  // Padder states, kept as plain constants so older code can compare codes directly
  typedef logic [2:0] state_t;
  localparam state_t ST_FILL = 3'd0;
  localparam state_t ST_PAD  = 3'd1;
  localparam state_t ST_ZERO = 3'd2;
  localparam state_t ST_LEN  = 3'd3;
  localparam state_t ST_OUT  = 3'd4;

  localparam logic [31:0] SHA1_H0 = 32'h6745_2301;
  localparam logic [31:0] SHA1_H1 = 32'hEFCD_AB89;
  localparam logic [31:0] SHA1_H2 = 32'h98BA_DCFE;
  localparam logic [31:0] SHA1_H3 = 32'h1032_5476;
  localparam logic [31:0] SHA1_H4 = 32'hC3D2_E1F0;

  // Byte idx (0 = most significant) of the 64-bit big-endian length field
  function automatic logic [7:0] len_byte(input logic [63:0] bits, input logic [2:0] idx);
    return bits[8*(7-idx) +: 8];
  endfunction

endpackage

// File: rtl/sha1_block_buf.sv
// 64-byte block buffer: one byte written per cycle at ptr, whole-block clear,
// packed output with byte 0 in the most significant lane.
module sha1_block_buf
  import sha1_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [5:0]            ptr,
  input  logic [7:0]            wdata,
  input  logic                  clr,
  output logic [BLOCK_BITS-1:0] data
);

  generate
    for (genvar gi = 0; gi < BLOCK_BYTES; gi++) begin : g_byte
      logic [7:0] byte_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          byte_reg <= '0;
        else if (clr)
          byte_reg <= '0;
        else if (we && (ptr == 6'(gi)))
          byte_reg <= wdata;
      end

      assign data[BLOCK_BITS-1-8*gi -: 8] = byte_reg;
    end
  endgenerate

endmodule

// File: rtl/sha1_padder.sv
// Byte-stream to 512-bit block formatter with FIPS 180-4 padding for the sha1 core.
// Define SHA1_PAD_LEN_CHECK_EN to saturate the byte counter and raise a sticky err_len.
module sha1_padder
  import sha1_pkg::*;
#(
  parameter int CNT_W = 61
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  input  logic                  in_nodata,
  output logic                  in_ready,
  output logic                  block_valid,
  output logic [BLOCK_BITS-1:0] block_data,
  output logic                  block_last,
  input  logic                  block_ready,
  output logic                  err_len
);

  state_t           state_reg, state_next;
  state_t           cont_reg, cont_next;
  logic [5:0]       ptr_reg, ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             in_ready_reg;
  logic             block_valid_reg;
  logic             block_last_reg, last_next;
  logic             buf_we, buf_clr;
  logic [7:0]       buf_wdata;
  logic             accept, data_beat;
  logic [63:0]      len_bits;

  assign accept    = in_valid & in_ready_reg;
  assign data_beat = accept & ~(in_last & in_nodata);
  assign len_bits  = 64'(count_reg) << 3;

  always_comb begin
    state_next = state_reg;
    cont_next  = cont_reg;
    ptr_next   = ptr_reg;
    count_next = count_reg;
    last_next  = block_last_reg;
    buf_we     = 1'b0;
    buf_wdata  = 8'h00;
    buf_clr    = 1'b0;

    case (state_reg)
      ST_FILL: begin
        if (data_beat) begin
          buf_we    = 1'b1;
          buf_wdata = in_data;
          ptr_next  = ptr_reg + 6'd1;
`ifdef SHA1_PAD_LEN_CHECK_EN
          if (!(&count_reg))
            count_next = count_reg + CNT_W'(1);
`else
          count_next = count_reg + CNT_W'(1);
`endif
          // A full block always goes out first; padding resumes afterwards if this was the end
          if (ptr_reg == 6'(BLOCK_BYTES-1)) begin
            state_next = ST_OUT;
            last_next  = 1'b0;
            cont_next  = in_last ? ST_PAD : ST_FILL;
          end else if (in_last) begin
            state_next = ST_PAD;
          end
        end else if (accept && in_last) begin
          state_next = ST_PAD;
        end
      end

      ST_PAD: begin
        buf_we    = 1'b1;
        buf_wdata = PAD_BYTE;
        ptr_next  = ptr_reg + 6'd1;
        if (ptr_reg == 6'(BLOCK_BYTES-1)) begin
          state_next = ST_OUT;
          last_next  = 1'b0;
          cont_next  = ST_ZERO;
        end else if (ptr_reg == 6'(LEN_POS-1)) begin
          state_next = ST_LEN;
        end else begin
          state_next = ST_ZERO;
        end
      end

      ST_ZERO: begin
        buf_we    = 1'b1;
        buf_wdata = 8'h00;
        ptr_next  = ptr_reg + 6'd1;
        if (ptr_reg == 6'(BLOCK_BYTES-1)) begin
          state_next = ST_OUT;
          last_next  = 1'b0;
          cont_next  = ST_ZERO;
        end else if (ptr_reg == 6'(LEN_POS-1)) begin
          state_next = ST_LEN;
        end
      end

      ST_LEN: begin
        buf_we    = 1'b1;
        buf_wdata = len_byte(len_bits, ptr_reg[2:0]);
        ptr_next  = ptr_reg + 6'd1;
        if (ptr_reg == 6'(BLOCK_BYTES-1)) begin
          state_next = ST_OUT;
          last_next  = 1'b1;
          cont_next  = ST_FILL;
        end
      end

      ST_OUT: begin
        if (block_ready) begin
          buf_clr    = 1'b1;
          ptr_next   = 6'd0;
          state_next = cont_reg;
          last_next  = 1'b0;
          if (block_last_reg) begin
            count_next = '0;
            state_next = ST_FILL;
          end
        end
      end

      default: begin
        state_next = ST_FILL;
        ptr_next   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= ST_FILL;
      cont_reg        <= ST_FILL;
      ptr_reg         <= 6'd0;
      count_reg       <= '0;
      in_ready_reg    <= 1'b0;
      block_valid_reg <= 1'b0;
      block_last_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cont_reg        <= cont_next;
      ptr_reg         <= ptr_next;
      count_reg       <= count_next;
      in_ready_reg    <= (state_next == ST_FILL);
      block_valid_reg <= (state_next == ST_OUT);
      block_last_reg  <= last_next;
    end
  end

`ifdef SHA1_PAD_LEN_CHECK_EN
  logic err_len_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      err_len_reg <= 1'b0;
    else if (data_beat && (&count_reg))
      err_len_reg <= 1'b1;
  end

  assign err_len = err_len_reg;
`else
  assign err_len = 1'b0;
`endif

  sha1_block_buf u_buf (
    .clk   (clk),
    .reset (reset),
    .we    (buf_we),
    .ptr   (ptr_reg),
    .wdata (buf_wdata),
    .clr   (buf_clr),
    .data  (block_data)
  );

  assign in_ready    = in_ready_reg;
  assign block_valid = block_valid_reg;
  assign block_last  = block_last_reg;

endmodule

// File: tb/tb_sha1_padder.sv
// Self-checking bench for sha1_padder: table vectors, corner sequences and random
// messages compared against a byte-queue padding model.
module tb_sha1_padder;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_last, in_nodata, block_ready;
  logic [7:0]   in_data;
  logic         in_ready, block_valid, block_last, err_len;
  logic [511:0] block_data;

  always #5 clk = ~clk;

  sha1_padder #(.CNT_W(61)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_nodata(in_nodata), .in_ready(in_ready),
    .block_valid(block_valid), .block_data(block_data), .block_last(block_last),
    .block_ready(block_ready), .err_len(err_len)
  );

`ifdef SHA1_PAD_LEN_CHECK_EN
  logic         in_ready4, block_valid4, block_last4, err_len4;
  logic [511:0] block_data4;

  sha1_padder #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_nodata(in_nodata), .in_ready(in_ready4),
    .block_valid(block_valid4), .block_data(block_data4), .block_last(block_last4),
    .block_ready(block_ready), .err_len(err_len4)
  );
`endif

  typedef struct {
    int len;
    int pat;
    bit nod;
    int nblk;
    int len16;
  } vec_t;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [7:0]   msg_q[$];
  logic [511:0] exp_q[$];
  logic [511:0] got_q[$];
  bit           got_last_q[$];
  bit           hold_mode = 1'b0;
  bit           held = 1'b0;
  int           vcnt = 0;
  int           last_wait = 0;
  logic [511:0] snap;
  logic         snap_last;

  function automatic void check_blk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endfunction

  function automatic void check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Block monitor: capture on handshake, check stability and in_ready while a block is offered
  always @(negedge clk) begin
    if (!block_valid) begin
      held = 1'b0;
      vcnt = 0;
    end else begin
      if (held) begin
        check_blk("hold_data", block_data, snap);
        check_bit("hold_last", block_last, snap_last);
      end else begin
        held      = 1'b1;
        snap      = block_data;
        snap_last = block_last;
      end
      check_bit("in_ready_low_during_out", in_ready, 1'b0);
      if (block_ready) begin
        got_q.push_back(block_data);
        got_last_q.push_back(block_last);
        $display("[TB] block %0d taken, last=%b, wait=%0d", got_q.size(), block_last, vcnt);
        last_wait = vcnt;
        held      = 1'b0;
        vcnt      = 0;
      end else begin
        vcnt++;
      end
    end
  end

  // Consumer: random ready, or held low for 20 valid cycles in hold mode
  initial begin
    block_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_mode) block_ready = (vcnt >= 20);
      else           block_ready = ($urandom_range(0, 2) == 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: message, 0x80, zeros to 56 mod 64, 64-bit big-endian bit count
  task automatic model();
    logic [7:0]      p[$];
    longint unsigned nbits;
    logic [511:0]    blk;
    p     = msg_q;
    nbits = 64'(msg_q.size()) * 8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(8'(nbits >> (8 * k)));
    exp_q.delete();
    for (int b = 0; b < p.size() / 64; b++) begin
      for (int i = 0; i < 64; i++) blk[511 - 8*i -: 8] = p[b*64 + i];
      exp_q.push_back(blk);
    end
  endtask

  task automatic fill_msg(input int len, input int pat);
    msg_q.delete();
    for (int i = 0; i < len; i++) begin
      case (pat)
        0:       msg_q.push_back(8'(8'h61 + i));
        1:       msg_q.push_back(8'hAA);
        default: msg_q.push_back(8'($urandom));
      endcase
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last, input logic nod);
    int t = 0;
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = last;
    in_nodata = nod;
    @(negedge clk);
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL in_ready_timeout: got 0 after %0d cycles, expected 1", t);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_nodata = 1'b0;
  endtask

  task automatic send_msg(input bit nod_end);
    for (int i = 0; i < msg_q.size(); i++) begin
      send_beat(msg_q[i], (!nod_end && (i == msg_q.size() - 1)), 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    if (nod_end || (msg_q.size() == 0)) send_beat(8'h00, 1'b1, 1'b1);
  endtask

  task automatic finish_msg(input string name);
    int t = 0;
    while ((got_q.size() < exp_q.size()) && (t < 3000)) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check_int({name, "_nblocks"}, got_q.size(), exp_q.size());
    for (int i = 0; (i < got_q.size()) && (i < exp_q.size()); i++) begin
      check_blk({name, "_block"}, got_q[i], exp_q[i]);
      check_bit({name, "_last"}, got_last_q[i], (i == exp_q.size() - 1));
    end
    $display("[TB] msg %s: %0d bytes, %0d blocks", name, msg_q.size(), got_q.size());
    @(posedge clk);
    #1;
  endtask

  task automatic run_msg(input string name, input bit nod_end);
    got_q.delete();
    got_last_q.delete();
    model();
    send_msg(nod_end);
    finish_msg(name);
  endtask

  initial begin
    vec_t         vecs[12];
    logic [511:0] lb;
    int           lat;
    int           rlen;

    vecs[0]  = '{3,   0, 1'b0, 1, 'h0018};
    vecs[1]  = '{0,   0, 1'b1, 1, 'h0000};
    vecs[2]  = '{55,  1, 1'b0, 1, 'h01B8};
    vecs[3]  = '{56,  2, 1'b0, 2, 'h01C0};
    vecs[4]  = '{57,  2, 1'b0, 2, 'h01C8};
    vecs[5]  = '{63,  2, 1'b0, 2, 'h01F8};
    vecs[6]  = '{64,  2, 1'b0, 2, 'h0200};
    vecs[7]  = '{64,  2, 1'b1, 2, 'h0200};
    vecs[8]  = '{3,   0, 1'b1, 1, 'h0018};
    vecs[9]  = '{119, 2, 1'b0, 2, 'h03B8};
    vecs[10] = '{120, 2, 1'b1, 3, 'h03C0};
    vecs[11] = '{128, 2, 1'b0, 3, 'h0400};

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    in_nodata = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_bit("rst_in_ready", in_ready, 1'b0);
    check_bit("rst_block_valid", block_valid, 1'b0);
    check_bit("rst_block_last", block_last, 1'b0);
    check_blk("rst_block_data", block_data, '0);
    check_bit("rst_err_len", err_len, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_bit("in_ready_before_first_clk", in_ready, 1'b0);
    @(posedge clk);
    #1;
    check_bit("in_ready_first_clk", in_ready, 1'b1);

    // Counter overflow: only observable with a narrow counter and the check enabled
`ifdef SHA1_PAD_LEN_CHECK_EN
    check_bit("err4_after_reset", err_len4, 1'b0);
`endif
    fill_msg(17, 0);
    run_msg("cnt17", 1'b0);
`ifdef SHA1_PAD_LEN_CHECK_EN
    check_bit("err4_saturated", err_len4, 1'b1);
`endif
    check_bit("err_len_main", err_len, 1'b0);

    for (int v = 0; v < 12; v++) begin
      fill_msg(vecs[v].len, vecs[v].pat);
      run_msg($sformatf("vec%0d", v), vecs[v].nod);
      check_int($sformatf("vec%0d_nblk_tbl", v), got_q.size(), vecs[v].nblk);
      if (got_q.size() > 0) begin
        lb = got_q[got_q.size() - 1];
        check_int($sformatf("vec%0d_lenfield", v), int'(lb[15:0]), vecs[v].len16);
      end
    end

    // "abc": padding latency from the last byte to block_valid is 64 - 3 cycles
    fill_msg(3, 0);
    got_q.delete();
    got_last_q.delete();
    model();
    send_beat(msg_q[0], 1'b0, 1'b0);
    send_beat(msg_q[1], 1'b0, 1'b0);
    send_beat(msg_q[2], 1'b1, 1'b0);
    check_bit("pad_in_ready", in_ready, 1'b0);
    lat = 0;
    while (!block_valid && (lat < 200)) begin
      @(posedge clk);
      lat++;
      #1;
    end
    check_int("pad_latency", lat, 61);
    finish_msg("abc_lat");
    if (got_q.size() > 0) begin
      lb = got_q[0];
      check_int("abc_head", int'(lb[511:480]), 32'h6162_6380);
      check_int("abc_byte63", int'(lb[7:0]), 'h18);
    end

    // 64 bytes with the consumer stalling 20 cycles on each block
    hold_mode = 1'b1;
    fill_msg(64, 1);
    run_msg("hold64", 1'b0);
    check_int("hold_wait", last_wait, 20);
    if (got_q.size() > 1) begin
      lb = got_q[1];
      check_int("hold64_blk2_byte0", int'(lb[511:504]), 'h80);
    end
    hold_mode = 1'b0;

    // Reset in the middle of a message discards everything
    fill_msg(30, 2);
    for (int i = 0; i < 30; i++) send_beat(msg_q[i], 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    check_bit("rst_mid_valid", block_valid, 1'b0);
    check_bit("rst_mid_ready", in_ready, 1'b0);
    check_blk("rst_mid_data", block_data, '0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    fill_msg(3, 0);
    run_msg("after_rst", 1'b0);

    for (int r = 0; r < 8; r++) begin
      rlen = $urandom_range(0, 150);
      fill_msg(rlen, 2);
      run_msg($sformatf("rand%0d", r), 1'(($urandom_range(0, 1))));
      if (got_q.size() > 0) begin
        lb = got_q[got_q.size() - 1];
        check_int($sformatf("rand%0d_lenfield", r), int'(lb[15:0]), (rlen * 8) & 'hFFFF);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
